// File: rtl/mux_n_pkg.sv
// ============================================================================
// Module   : mux_n_pkg
// Brief    : Shared mode encoding and width helper for the N-channel selector.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mux_n_pkg;

    typedef enum logic {
        MODE_DIRECT = 1'b0,
        MODE_SCAN   = 1'b1
    } mode_e;

    // Index width for n items; never below 1 so a 2-channel build still has a select bit.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mux_n_reg_rr_pick.sv
// ============================================================================
// Module   : rr_pick
// Brief    : Combinational round-robin first-set finder starting at i_ptr.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick
    import mux_n_pkg::*;
#(
    parameter  int CHANNELS = 4,
    localparam int SEL_W    = clog2(CHANNELS)
) (
    input  logic [CHANNELS-1:0] i_valid,
    input  logic [SEL_W-1:0]    i_ptr,
    output logic                o_found,
    output logic [SEL_W-1:0]    o_index
);

    localparam logic [SEL_W:0] c_CH = (SEL_W + 1)'(CHANNELS);

    logic [SEL_W:0] w_idx;

    // Walk offsets from farthest to nearest so the nearest valid channel wins.
    always_comb begin
        o_found = 1'b0;
        o_index = '0;
        w_idx   = '0;
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            w_idx = {1'b0, i_ptr} + (SEL_W + 1)'(k);
            if (w_idx >= c_CH) w_idx = w_idx - c_CH;
            if (i_valid[w_idx[SEL_W-1:0]]) begin
                o_found = 1'b1;
                o_index = w_idx[SEL_W-1:0];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/mux_n_reg.sv
// ============================================================================
// Module   : mux_n_reg
// Brief    : Registered N-channel selector, direct or round-robin scan mode.
//            Optional out_parity port enabled by MUX_N_REG_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux_n_reg
    import mux_n_pkg::*;
#(
    parameter  int WIDTH    = 4,
    parameter  int CHANNELS = 4,
    localparam int SEL_W    = clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    input  logic [CHANNELS*WIDTH-1:0] ch_data,
    input  logic [CHANNELS-1:0]       ch_valid,
    output logic [CHANNELS-1:0]       ch_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_ch,
    output logic                      out_valid,
    input  logic                      out_ready
`ifdef MUX_N_REG_PARITY_EN
   ,output logic                      out_parity
`endif
);

    localparam logic [SEL_W-1:0] c_LAST = SEL_W'(CHANNELS - 1);

    logic [WIDTH-1:0] r_out_data_q,  w_out_data_d;
    logic [SEL_W-1:0] r_out_ch_q,    w_out_ch_d;
    logic             r_out_valid_q, w_out_valid_d;
    logic [SEL_W-1:0] r_ptr_q,       w_ptr_d;

    logic             w_load;
    logic             w_scan_found;
    logic [SEL_W-1:0] w_scan_idx;
    logic             w_dir_found;
    logic             w_found;
    logic [SEL_W-1:0] w_cand;
    logic [WIDTH-1:0] w_cand_data;
    logic             w_xfer;

    assign w_load = ~r_out_valid_q | out_ready;

    rr_pick #(
        .CHANNELS (CHANNELS)
    ) u_rr_pick (
        .i_valid (ch_valid),
        .i_ptr   (r_ptr_q),
        .o_found (w_scan_found),
        .o_index (w_scan_idx)
    );

    // Compare against every legal index so an out-of-range sel simply matches nothing.
    always_comb begin
        w_dir_found = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if ((sel == SEL_W'(i)) && ch_valid[i]) w_dir_found = 1'b1;
        end
    end

    always_comb begin
        if (mode_e'(mode) == MODE_SCAN) begin
            w_found = w_scan_found;
            w_cand  = w_scan_idx;
        end else begin
            w_found = w_dir_found;
            w_cand  = sel;
        end
    end

    assign w_xfer = w_load & w_found & ~rst;

    always_comb begin
        w_cand_data = '0;
        ch_ready    = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (w_cand == SEL_W'(i)) begin
                w_cand_data = ch_data[i*WIDTH +: WIDTH];
                ch_ready[i] = w_xfer;
            end
        end
    end

    always_comb begin
        w_out_data_d  = r_out_data_q;
        w_out_ch_d    = r_out_ch_q;
        w_out_valid_d = r_out_valid_q;
        w_ptr_d       = r_ptr_q;
        if (w_load) begin
            if (w_found) begin
                w_out_data_d  = w_cand_data;
                w_out_ch_d    = w_cand;
                w_out_valid_d = 1'b1;
                if (mode_e'(mode) == MODE_SCAN) begin
                    w_ptr_d = (w_cand == c_LAST) ? '0 : w_cand + 1'b1;
                end
            end else begin
                w_out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_data_q  <= '0;
            r_out_ch_q    <= '0;
            r_out_valid_q <= 1'b0;
            r_ptr_q       <= '0;
        end else begin
            r_out_data_q  <= w_out_data_d;
            r_out_ch_q    <= w_out_ch_d;
            r_out_valid_q <= w_out_valid_d;
            r_ptr_q       <= w_ptr_d;
        end
    end

    assign out_data  = r_out_data_q;
    assign out_ch    = r_out_ch_q;
    assign out_valid = r_out_valid_q;

`ifdef MUX_N_REG_PARITY_EN
    logic r_out_parity_q, w_out_parity_d;

    always_comb begin
        w_out_parity_d = r_out_parity_q;
        if (w_load && w_found) w_out_parity_d = ^w_cand_data;
    end

    always_ff @(posedge clk) begin
        if (rst) r_out_parity_q <= 1'b0;
        else     r_out_parity_q <= w_out_parity_d;
    end

    assign out_parity = r_out_parity_q;
`endif

endmodule

`default_nettype wire
